// File: rtl/r5_pkg.sv
// ---------------------------------------------------------------------------
// r5_pkg : shared definitions for the Radix-5 FFT datapath stages.
//   RADIX      - butterfly radix (samples per group)
//   DATA_W_DEF - default width of one real/imag component
//   slot_idx_t - index of a sample slot within a group (0..4)
//   grp_width  - width of the group index for an N-point frame,
//                max(1, clog2(N/RADIX))
// ---------------------------------------------------------------------------
package r5_pkg;

    localparam int RADIX      = 5;
    localparam int DATA_W_DEF = 32;

    typedef logic [2:0] slot_idx_t;

    // Group-index width for a frame of n_points samples; never below one bit.
    function automatic int grp_width(input int n_points);
        int groups;
        int w;
        groups = n_points / RADIX;
        w      = 32'sd1;
        while ((32'sd1 << w) < groups) begin
            w = w + 32'sd1;
        end
        return w;
    endfunction

endpackage

// File: rtl/r5_gather.sv
// ---------------------------------------------------------------------------
// r5_gather : front-end gather stage of the Radix-5 FFT.
// Collects five consecutive complex samples and presents them in parallel
// to the radix-5 butterfly, together with the group index in the frame.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   flush      (only with R5_GATHER_FLUSH_EN) emit a partial group,
//              missing slots as zero
//   in_valid   a_re/a_img carry a sample this cycle
//   a_re/a_img sample real / imaginary part
//   out_valid  one-cycle pulse, x_re/x_im hold a complete group
//   out_last   qualifies out_valid: final group of the frame
//   out_grp    index of the emitted group
//   x_re/x_im  slot k (arrival order) at bits [k*DATA_W +: DATA_W]
//
// Configuration macro: R5_GATHER_FLUSH_EN adds the flush input.
// ---------------------------------------------------------------------------
module r5_gather
    import r5_pkg::*;
#(
    parameter  int DATA_W   = DATA_W_DEF,
    parameter  int N_POINTS = 25,
    localparam int GRP_W    = grp_width(N_POINTS)
) (
    input  logic                    clk,
    input  logic                    rst_n,
`ifdef R5_GATHER_FLUSH_EN
    input  logic                    flush,
`endif
    input  logic                    in_valid,
    input  logic [DATA_W-1:0]       a_re,
    input  logic [DATA_W-1:0]       a_img,
    output logic                    out_valid,
    output logic                    out_last,
    output logic [GRP_W-1:0]        out_grp,
    output logic [RADIX*DATA_W-1:0] x_re,
    output logic [RADIX*DATA_W-1:0] x_im
);

    localparam int              NGRP     = N_POINTS / RADIX;
    localparam logic [GRP_W-1:0] LAST_GRP = GRP_W'(NGRP - 1);

    slot_idx_t               cnt_r;
    logic [GRP_W-1:0]        grp_r;
    // Only slots 0..3 are staged; slot 4 is taken straight from the input.
    logic [DATA_W-1:0]       stg_re_r [RADIX-1];
    logic [DATA_W-1:0]       stg_im_r [RADIX-1];
    logic                    out_valid_r;
    logic                    out_last_r;
    logic [GRP_W-1:0]        out_grp_r;
    logic [RADIX*DATA_W-1:0] x_re_r;
    logic [RADIX*DATA_W-1:0] x_im_r;

    logic                    flush_s;
    logic                    emit_s;
    slot_idx_t               cnt_nxt_s;
    logic [RADIX*DATA_W-1:0] grp_re_s;
    logic [RADIX*DATA_W-1:0] grp_im_s;

    // Emit decision, next slot count and the group word to be loaded.
    always_comb begin
        flush_s   = 1'b0;
        emit_s    = 1'b0;
        cnt_nxt_s = cnt_r;
        grp_re_s  = '0;
        grp_im_s  = '0;
`ifdef R5_GATHER_FLUSH_EN
        // A sample always wins over flush; an empty group never flushes.
        flush_s = flush && !in_valid && (cnt_r != 3'd0);
`else
        flush_s = 1'b0;
`endif
        emit_s = (in_valid && (cnt_r == 3'd4)) || flush_s;

        if (in_valid) begin
            cnt_nxt_s = (cnt_r == 3'd4) ? 3'd0 : cnt_r + 3'd1;
        end else if (flush_s) begin
            cnt_nxt_s = 3'd0;
        end else begin
            cnt_nxt_s = cnt_r;
        end

        // Slots not yet filled in this group read as zero (stale data masked).
        for (int k = 0; k < RADIX - 1; k++) begin
            if (slot_idx_t'(k) < cnt_r) begin
                grp_re_s[k*DATA_W +: DATA_W] = stg_re_r[k];
                grp_im_s[k*DATA_W +: DATA_W] = stg_im_r[k];
            end else begin
                grp_re_s[k*DATA_W +: DATA_W] = '0;
                grp_im_s[k*DATA_W +: DATA_W] = '0;
            end
        end
        if (in_valid) begin
            grp_re_s[(RADIX-1)*DATA_W +: DATA_W] = a_re;
            grp_im_s[(RADIX-1)*DATA_W +: DATA_W] = a_img;
        end else begin
            grp_re_s[(RADIX-1)*DATA_W +: DATA_W] = '0;
            grp_im_s[(RADIX-1)*DATA_W +: DATA_W] = '0;
        end
    end

    // Staging, counters and registered group outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_r       <= 3'd0;
            grp_r       <= '0;
            out_valid_r <= 1'b0;
            out_last_r  <= 1'b0;
            out_grp_r   <= '0;
            x_re_r      <= '0;
            x_im_r      <= '0;
            for (int k = 0; k < RADIX - 1; k++) begin
                stg_re_r[k] <= '0;
                stg_im_r[k] <= '0;
            end
        end else begin
            cnt_r <= cnt_nxt_s;
            if (in_valid) begin
                for (int k = 0; k < RADIX - 1; k++) begin
                    if (cnt_r == slot_idx_t'(k)) begin
                        stg_re_r[k] <= a_re;
                        stg_im_r[k] <= a_img;
                    end
                end
            end
            out_valid_r <= emit_s;
            out_last_r  <= emit_s && (grp_r == LAST_GRP);
            if (emit_s) begin
                x_re_r    <= grp_re_s;
                x_im_r    <= grp_im_s;
                out_grp_r <= grp_r;
                grp_r     <= (grp_r == LAST_GRP) ? '0 : grp_r + GRP_W'(1);
            end
        end
    end

    assign out_valid = out_valid_r;
    assign out_last  = out_last_r;
    assign out_grp   = out_grp_r;
    assign x_re      = x_re_r;
    assign x_im      = x_im_r;

endmodule

// File: tb/tb_r5_gather.sv
// ---------------------------------------------------------------------------
// tb_r5_gather : directed bench for r5_gather. A 25-point instance and a
// 5-point instance share the same input stream.
// ---------------------------------------------------------------------------
module tb_r5_gather;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         flush = 1'b0;
    logic         in_valid = 1'b0;
    logic [31:0]  a_re = 32'd0;
    logic [31:0]  a_img = 32'd0;

    logic         ov, ol, ov5, ol5;
    logic [2:0]   og;
    logic [0:0]   og5;
    logic [159:0] xr, xi, xr5, xi5;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    r5_gather #(.DATA_W(32), .N_POINTS(25)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef R5_GATHER_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .a_re(a_re), .a_img(a_img),
        .out_valid(ov), .out_last(ol), .out_grp(og), .x_re(xr), .x_im(xi)
    );

    r5_gather #(.DATA_W(32), .N_POINTS(5)) dut5 (
        .clk(clk), .rst_n(rst_n),
`ifdef R5_GATHER_FLUSH_EN
        .flush(flush),
`endif
        .in_valid(in_valid), .a_re(a_re), .a_img(a_img),
        .out_valid(ov5), .out_last(ol5), .out_grp(og5), .x_re(xr5), .x_im(xi5)
    );

    task automatic chk(input string tag, input logic [159:0] obs, input logic [159:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected packed real parts base..base+4, slot k = base+k.
    function automatic logic [159:0] pk_re(input int base);
        logic [159:0] r;
        for (int k = 0; k < 5; k++) r[k*32 +: 32] = 32'(base + k);
        return r;
    endfunction

    function automatic logic [159:0] pk_im(input int base);
        logic [159:0] r;
        for (int k = 0; k < 5; k++) r[k*32 +: 32] = 32'(-(base + k));
        return r;
    endfunction

    // Present one cycle of input, then sample 1 time unit after the edge.
    task automatic send(input logic v, input int n);
        in_valid = v;
        a_re     = 32'(n);
        a_img    = 32'(-n);
        @(posedge clk);
        #1;
    endtask

    // One 25-sample frame (re = n, im = -n); optional idle cycle after each.
    task automatic frame(input bit gaps, input int hold_base, input int hold_grp);
        int hb, hg;
        hb = hold_base;
        hg = hold_grp;
        for (int n = 0; n < 25; n++) begin
            send(1'b1, n);
            if (n % 5 == 4) begin
                chk($sformatf("valid_n%0d", n), 160'(ov), 160'd1);
                chk($sformatf("grp_n%0d", n), 160'(og), 160'(n / 5));
                chk($sformatf("last_n%0d", n), 160'(ol), 160'(n == 24));
                chk($sformatf("xre_n%0d", n), xr, pk_re(n - 4));
                chk($sformatf("xim_n%0d", n), xi, pk_im(n - 4));
                chk($sformatf("v5_n%0d", n), 160'({ov5, ol5, og5}), 160'(3'b110));
                chk($sformatf("x5_n%0d", n), xr5, pk_re(n - 4));
                hb = n - 4;
                hg = n / 5;
            end else begin
                chk($sformatf("novalid_n%0d", n), 160'({ov, ol, ov5}), 160'd0);
            end
            if (gaps) begin
                send(1'b0, 999);
                chk($sformatf("gapvalid_n%0d", n), 160'({ov, ol, ov5}), 160'd0);
                chk($sformatf("holdre_n%0d", n), xr, pk_re(hb));
                chk($sformatf("holdim_n%0d", n), xi, pk_im(hb));
                chk($sformatf("holdgrp_n%0d", n), 160'(og), 160'(hg));
            end
        end
    endtask

    initial begin
        // Reset state
        #12;
        chk("rst_valid", 160'({ov, ol}), 160'd0);
        chk("rst_grp", 160'(og), 160'd0);
        chk("rst_xre", xr, 160'd0);
        chk("rst_xim", xi, 160'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Back-to-back frame, gapped frame, then another back-to-back frame
        frame(1'b0, 0, 0);
        frame(1'b1, 20, 4);
        frame(1'b0, 20, 4);
        send(1'b0, 0);
        chk("after_frames_valid", 160'({ov, ol}), 160'd0);

        // Reset in the middle of a group
        send(1'b1, 50);
        send(1'b1, 51);
        send(1'b1, 52);
        in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_rst_xre", xr, 160'd0);
        chk("async_rst_grp", 160'(og), 160'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int n = 100; n < 104; n++) begin
            send(1'b1, n);
            chk($sformatf("rst_partial_n%0d", n), 160'({ov, ov5}), 160'd0);
        end
        send(1'b1, 104);
        chk("post_rst_valid", 160'(ov), 160'd1);
        chk("post_rst_grp", 160'(og), 160'd0);
        chk("post_rst_last", 160'(ol), 160'd0);
        chk("post_rst_xre", xr, pk_re(100));
        chk("post_rst_xim", xi, pk_im(100));

`ifdef R5_GATHER_FLUSH_EN
        // Partial group flushed with missing slots zeroed
        send(1'b1, 7);
        send(1'b1, 8);
        chk("pre_flush_valid", 160'(ov), 160'd0);
        flush = 1'b1;
        send(1'b0, 0);
        flush = 1'b0;
        chk("flush_valid", 160'(ov), 160'd1);
        chk("flush_grp", 160'(og), 160'd1);
        chk("flush_last", 160'(ol), 160'd0);
        chk("flush_xre", xr, {96'd0, 32'd8, 32'd7});
        chk("flush_xim", xi, {96'd0, 32'hFFFF_FFF8, 32'hFFFF_FFF9});
        chk("flush5", 160'({ov5, ol5, og5}), 160'(3'b110));
        send(1'b0, 0);
        chk("flush_pulse_width", 160'(ov), 160'd0);
        flush = 1'b1;
        send(1'b0, 0);
        flush = 1'b0;
        chk("flush_empty", 160'({ov, ov5}), 160'd0);
        chk("flush_empty_hold", xr, {96'd0, 32'd8, 32'd7});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
